// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver.
//   uart_state_e            : receiver FSM states
//   UART_DATA_BITS          : data bits per frame (LSB first)
//   UART_STOP_BITS          : stop bits per frame
//   UART_OVERSAMPLE_DEFAULT : default tick pulses per bit period
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } uart_state_e;

    localparam int UART_DATA_BITS          = 8;
    localparam int UART_STOP_BITS          = 2;
    localparam int UART_OVERSAMPLE_DEFAULT = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so the line reads idle straight out of reset.
//   clk   : system clock
//   reset : synchronous active-high reset
//   rx_i  : asynchronous serial input
//   rxs_o : synchronized serial line
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx_i,
    output logic rxs_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= rx_i;
            s2_q <= s1_q;
        end
    end

    assign rxs_o = s2_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 1 start, 8 data (LSB first), 1 even-parity, 2 stop bits.
// Oversampled by the tick strobe; every bit is sampled once at mid-bit.
// Optional feature macro: UART_RX_PARITY_CHECK_EN (enables parity_error;
// otherwise the parity bit is consumed for timing only and the flag is 0).
//   clk           : system clock
//   reset         : synchronous active-high reset
//   tick          : one-clk pulse at OVERSAMPLE x baud
//   rx            : asynchronous serial line, idle high
//   data_ack      : consumer has taken data_out
//   data_out      : last received byte
//   data_valid    : data_out holds an unconsumed byte
//   parity_error  : parity mismatch on the byte in data_out
//   frame_error   : a stop bit of the byte in data_out was 0
//   overrun_error : a frame completed while data_valid was high (sticky)
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       rx,
    input  logic       data_ack,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       frame_error,
    output logic       overrun_error
);

    localparam int              CNT_W    = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_BITS - 1);

    logic rxs;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .rx_i  (rx),
        .rxs_o (rxs)
    );

    uart_state_e               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      fe_q, fe_d;
    logic                      prev_q;
    logic                      done;
    logic [CNT_W-1:0]          cnt_inc;
    logic                      sample;

    logic [7:0] data_out_q;
    logic       data_valid_q;
    logic       frame_error_q;
    logic       overrun_error_q;

`ifdef UART_RX_PARITY_CHECK_EN
    logic par_q, par_d;
    logic parity_error_q;
`endif

    assign cnt_inc = cnt_q + 1'b1;
    assign sample  = tick && (cnt_q == CNT_LAST);

    // Edge detect runs at tick rate so idle cycles without tick leave it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else if (tick) begin
            prev_q <= rxs;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        fe_d    = fe_q;
        done    = 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (tick && prev_q && !rxs) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    fe_d    = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (cnt_inc == CNT_HALF) begin
                        // Line must still be low half a bit in, else it was a glitch.
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2: begin
                if (tick) begin
                    if (sample) begin
                        cnt_d = '0;
                        case (state_q)
                            ST_DATA: begin
                                shift_d = {rxs, shift_q[UART_DATA_BITS-1:1]};
                                if (idx_q == IDX_LAST) begin
                                    state_d = ST_PARITY;
                                end else begin
                                    idx_d = idx_q + 3'd1;
                                end
                            end
                            ST_PARITY: begin
`ifdef UART_RX_PARITY_CHECK_EN
                                par_d = rxs;
`endif
                                state_d = ST_STOP1;
                            end
                            ST_STOP1: begin
                                if (!rxs) fe_d = 1'b1;
                                state_d = ST_STOP2;
                            end
                            default: begin
                                done    = 1'b1;
                                state_d = ST_IDLE;
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            fe_q    <= fe_d;
        end
    end

    // Frame payload registers carry no control meaning and need no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef UART_RX_PARITY_CHECK_EN
        par_q   <= par_d;
`endif
    end

    // Completion has priority over data_ack in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q      <= '0;
            data_valid_q    <= 1'b0;
            frame_error_q   <= 1'b0;
            overrun_error_q <= 1'b0;
        end else if (done) begin
            data_out_q    <= shift_q;
            data_valid_q  <= 1'b1;
            frame_error_q <= fe_q | ~rxs;
            if (data_valid_q && !data_ack) overrun_error_q <= 1'b1;
        end else if (data_ack && data_valid_q) begin
            data_valid_q <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_error_q <= 1'b0;
        end else if (done) begin
            parity_error_q <= (^shift_q) ^ par_q;
        end
    end
    assign parity_error = parity_error_q;
`else
    assign parity_error = 1'b0;
`endif

    assign data_out      = data_out_q;
    assign data_valid    = data_valid_q;
    assign frame_error   = frame_error_q;
    assign overrun_error = overrun_error_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver (OVERSAMPLE=16): table of frames plus
// hand-written sequences for false start, overrun/ack and mid-frame reset.
module tb_uart_receiver;

    localparam int OS = 16;

`ifdef UART_RX_PARITY_CHECK_EN
    localparam logic PE_EXP = 1'b1;
`else
    localparam logic PE_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       rx;
    logic       data_ack;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       frame_error;
    logic       overrun_error;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       s1;
        logic       s2;
        logic       ack;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
        logic       exp_oe;
    } vec_t;

    vec_t vecs[7];

    uart_receiver #(.OVERSAMPLE(OS)) dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .rx            (rx),
        .data_ack      (data_ack),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .parity_error  (parity_error),
        .frame_error   (frame_error),
        .overrun_error (overrun_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    endtask

    task automatic chk_all(input string name, input logic [7:0] d, input logic v,
                           input logic pe, input logic fe, input logic oe);
        chk({name, ".data_out"},      data_out,      d);
        chk({name, ".data_valid"},    data_valid,    v);
        chk({name, ".parity_error"},  parity_error,  pe);
        chk({name, ".frame_error"},   frame_error,   fe);
        chk({name, ".overrun_error"}, overrun_error, oe);
    endtask

    task automatic do_tick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (OS) do_tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic s1, input logic s2);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(s1);
        send_bit(s2);
        rx = 1'b1;
        repeat (8) do_tick();
    endtask

    task automatic do_ack();
        @(negedge clk) data_ack = 1'b1;
        @(negedge clk) data_ack = 1'b0;
    endtask

    initial begin
        logic [7:0] partial;

        //            data   par   s1    s2    ack   exp    pe      fe    oe
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0,   1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 8'h07, PE_EXP, 1'b0, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0,   1'b1, 1'b0};
        vecs[3] = '{8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0,   1'b0, 1'b0};
        vecs[4] = '{8'h66, 1'b0, 1'b0, 1'b1, 1'b1, 8'h66, 1'b0,   1'b1, 1'b0};
        vecs[5] = '{8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0,   1'b0, 1'b0};
        vecs[6] = '{8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22, 1'b0,   1'b0, 1'b1};

        tick     = 1'b0;
        rx       = 1'b1;
        data_ack = 1'b0;
        reset    = 1'b1;
        repeat (4) @(negedge clk);
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (4) do_tick();
        chk("idle.data_valid", data_valid, 1'b0);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].ack) do_ack();
            send_frame(vecs[i].data, vecs[i].par, vecs[i].s1, vecs[i].s2);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_data, 1'b1,
                    vecs[i].exp_pe, vecs[i].exp_fe, vecs[i].exp_oe);
        end

        // Ack after overrun: valid drops, overrun stays.
        do_ack();
        @(negedge clk);
        chk_all("ack_after_overrun", 8'h22, 1'b0, 1'b0, 1'b0, 1'b1);

        // Ack while nothing is valid is ignored.
        do_ack();
        chk("stray_ack.data_valid", data_valid, 1'b0);

        // False start: low for 4 ticks only.
        rx = 1'b0;
        repeat (4) do_tick();
        rx = 1'b1;
        repeat (40) do_tick();
        chk("false_start.data_valid", data_valid, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1, 1'b1);
        chk_all("after_false_start", 8'h81, 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset during data bit 4 discards the partial frame.
        partial = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(partial[i]);
        rx = partial[4];
        repeat (5) do_tick();
        @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_all("midframe_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (OS * 12) do_tick();
        chk("post_reset_idle.data_valid", data_valid, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b1);
        chk_all("after_reset_F0", 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
